// File: rtl/x25519_mult_squeeze_pkg.sv
// Shared X25519 register-file types: bignum layout, limb geometry and squeeze FSM states.
package Curve25519Registers;
  localparam int NLIMBS     = 32;
  localparam int WORD_W     = 32;
  localparam int LIMB_W     = 8;
  localparam int TOP_LIMB_W = 7;
  localparam int FOLD       = 19;
  localparam int ACC_W      = 40;

  typedef struct packed {
    logic [NLIMBS-1:0][WORD_W-1:0] blocks;
  } bignum_t;

  typedef enum logic [2:0] {
    SQZ_IDLE,
    SQZ_COLLECT,
    SQZ_SQ1,
    SQZ_SQ1_TOP,
    SQZ_SQ2,
    SQZ_SQ2_TOP
  } sqz_state_e;
endpackage

// File: rtl/x25519_mult_squeeze_step.sv
// One carry-squeeze limb step; on the top limb the overflow above bit 255 is folded by 19.
module x25519_squeeze_step
  import Curve25519Registers::*;
(
  input  logic [ACC_W-1:0]  i_u,
  input  logic [WORD_W-1:0] i_limb,
  input  logic              i_top,
  output logic [WORD_W-1:0] o_limb,
  output logic [ACC_W-1:0]  o_u
);
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_hi;

  assign w_sum = i_u + ACC_W'(i_limb);
  assign w_hi  = w_sum >> TOP_LIMB_W;

  always_comb begin
    if (i_top) begin
      o_limb = WORD_W'(w_sum[TOP_LIMB_W-1:0]);
      o_u    = ACC_W'(FOLD) * w_hi;
    end else begin
      o_limb = WORD_W'(w_sum[LIMB_W-1:0]);
      o_u    = w_sum >> LIMB_W;
    end
  end
endmodule

// File: rtl/x25519_mult_squeeze.sv
// Collects 32 product words, runs a two-round 8-bit-limb carry squeeze and emits a bignum.
// Optional sticky err on dropped words: define X25519_SQUEEZE_ERR_EN.
module x25519_mult_squeeze
  import Curve25519Registers::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [WORD_W-1:0] din,
  output logic              busy,
  output logic              out_valid,
  output bignum_t           out
`ifdef X25519_SQUEEZE_ERR_EN
  ,
  output logic              err
`endif
);
  sqz_state_e                    r_state, w_next;
  logic [4:0]                    r_cnt;
  logic [ACC_W-1:0]              r_u;
  logic [NLIMBS-1:0][WORD_W-1:0] r_buf;
  logic [NLIMBS-1:0][WORD_W-1:0] w_final;
  logic                          w_top, w_sq, w_capture;
  logic [4:0]                    w_idx;
  logic [WORD_W-1:0]             w_limb;
  logic [ACC_W-1:0]              w_u;

  // Single step instance serves both rounds; r_cnt is 31 on the top cycles.
  x25519_squeeze_step u_step (
    .i_u    (r_u),
    .i_limb (r_buf[r_cnt]),
    .i_top  (w_top),
    .o_limb (w_limb),
    .o_u    (w_u)
  );

  always_comb begin
    w_next    = r_state;
    w_top     = 1'b0;
    w_sq      = 1'b0;
    w_capture = 1'b0;
    w_idx     = r_cnt;
    busy      = (r_state != SQZ_IDLE);
    case (r_state)
      SQZ_IDLE: begin
        w_idx     = 5'd0;
        w_capture = din_valid;
        if (din_valid) w_next = SQZ_COLLECT;
      end
      SQZ_COLLECT: begin
        w_capture = din_valid;
        if (din_valid && r_cnt == 5'd31) w_next = SQZ_SQ1;
      end
      SQZ_SQ1: begin
        w_sq = 1'b1;
        if (r_cnt == 5'd30) w_next = SQZ_SQ1_TOP;
      end
      SQZ_SQ1_TOP: begin
        w_sq   = 1'b1;
        w_top  = 1'b1;
        w_next = SQZ_SQ2;
      end
      SQZ_SQ2: begin
        w_sq = 1'b1;
        if (r_cnt == 5'd30) w_next = SQZ_SQ2_TOP;
      end
      SQZ_SQ2_TOP: begin
        w_sq   = 1'b1;
        w_top  = 1'b1;
        w_next = SQZ_IDLE;
      end
      default: w_next = SQZ_IDLE;
    endcase
  end

  always_comb begin
    w_final             = r_buf;
    w_final[NLIMBS-1]   = w_limb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SQZ_IDLE;
      r_cnt     <= 5'd0;
      r_u       <= '0;
      r_buf     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      r_state   <= w_next;
      out_valid <= 1'b0;
      if (w_capture) begin
        // cnt wraps 31 -> 0, which is exactly the j=0 start of the first round.
        r_buf[w_idx] <= din;
        r_cnt        <= w_idx + 5'd1;
        r_u          <= '0;
      end else if (w_sq) begin
        r_buf[r_cnt] <= w_limb;
        r_u          <= w_u;
        r_cnt        <= w_top ? 5'd0 : r_cnt + 5'd1;
        if (r_state == SQZ_SQ2_TOP) begin
          out.blocks <= w_final;
          out_valid  <= 1'b1;
        end
      end
    end
  end

`ifdef X25519_SQUEEZE_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)                    err <= 1'b0;
    else if (w_sq && din_valid) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_x25519_mult_squeeze.sv
// Randomized bench for x25519_mult_squeeze against a big-integer squeeze model.
module tb_x25519_mult_squeeze;
  import Curve25519Registers::*;

  typedef logic [31:0] words_t [32];

  logic    clk = 1'b0;
  logic    rst, din_valid;
  logic [31:0] din;
  logic    busy, out_valid;
  bignum_t out;
`ifdef X25519_SQUEEZE_ERR_EN
  logic    err;
`endif

  int n_chk = 0;
  int n_err = 0;

  x25519_mult_squeeze dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .busy      (busy),
    .out_valid (out_valid),
    .out       (out)
`ifdef X25519_SQUEEZE_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Value model: X = sum w_i*2^(8i); round 1 leaves L = X mod 2^255 and carries H = X>>255;
  // round 2 adds 19*H into L and keeps the low 255 bits as 8-bit limbs.
  function automatic bignum_t ref_squeeze(input words_t w);
    logic [511:0] x, l, h, y, m;
    bignum_t r;
    x = '0;
    for (int i = 0; i < 32; i++) x = x + (512'(w[i]) << (8 * i));
    m = (512'd1 << 255) - 512'd1;
    l = x & m;
    h = x >> 255;
    y = (l + h * 512'd19) & m;
    for (int k = 0; k < 32; k++) r.blocks[k] = {24'd0, y[8*k +: 8]};
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input words_t w, input int gap_max, input int drop_at);
    bignum_t exp;
    int n;
    bit done;
    exp = ref_squeeze(w);
    for (int i = 0; i < 32; i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) cycle();
      din_valid = 1'b1;
      din       = w[i];
      cycle();
      din_valid = 1'b0;
      din       = $urandom;
      if (i == 0) check({nm, "_ov_pulse"}, out_valid, 1'b0);
      check($sformatf("%s_busy_w%0d", nm, i), busy, 1'b1);
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      cycle();
      n++;
      din_valid = (n == drop_at);
      din       = $urandom;
      if (out_valid) done = 1'b1;
      else if (!busy) begin
        check({nm, "_busy_sq"}, busy, 1'b1);
        done = 1'b1;
      end
    end
    din_valid = 1'b0;
    check({nm, "_latency"}, n, 64);
    check({nm, "_busy_done"}, busy, 1'b0);
    for (int k = 0; k < 32; k++)
      check($sformatf("%s_blk%0d", nm, k), out.blocks[k], exp.blocks[k]);
  endtask

  initial begin
    words_t w;
    bignum_t hold;
    int ov_seen;

    rst = 1'b1;
    din_valid = 1'b0;
    din = '0;
    repeat (3) cycle();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_ov", out_valid, 1'b0);
    check("rst_out", (out == '0), 1'b1);
`ifdef X25519_SQUEEZE_ERR_EN
    check("rst_err", err, 1'b0);
`endif

    // 256 at index 0 carries into limb 1
    for (int i = 0; i < 32; i++) w[i] = '0;
    w[0] = 32'd256;
    run_op("t1", w, 0, -1);
    check("t1_limb1", out.blocks[1], 32'h01);

    // p passes through unchanged
    w[0] = 32'hED;
    for (int i = 1; i < 31; i++) w[i] = 32'hFF;
    w[31] = 32'h7F;
    run_op("t2", w, 2, -1);
    check("t2_limb0", out.blocks[0], 32'hED);

    // Overflow from the top word folds into limbs 0..3
    for (int i = 0; i < 32; i++) w[i] = '0;
    w[31] = 32'hFFFFFFFF;
    run_op("t3", w, 1, -1);
    check("t3_limb3", out.blocks[3], 32'h25);
    check("t3_limb31", out.blocks[31], 32'h7F);

    // 2^255 folds to 19
    w[31] = 32'd128;
    run_op("t4", w, 0, -1);
    check("t4_limb0", out.blocks[0], 32'h13);

    // Hold: out stays put while idle
    hold = out;
    repeat (5) cycle();
    check("hold_out", (out == hold), 1'b1);
    check("hold_ov", out_valid, 1'b0);

    // Random operations, some back-to-back, some with words dropped mid-squeeze
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) w[i] = $urandom;
      if (t == 2) for (int i = 0; i < 32; i++) w[i] = 32'hFFFFFFFF;
      run_op($sformatf("r%0d", t), w, (t % 3 == 0) ? 0 : 2,
             (t % 2 == 1) ? int'($urandom_range(62, 1)) : -1);
    end

`ifdef X25519_SQUEEZE_ERR_EN
    check("err_sticky", err, 1'b1);
`endif

    // Abort during the second round; no result may appear
    for (int i = 0; i < 32; i++) w[i] = $urandom;
    for (int i = 0; i < 32; i++) begin
      din_valid = 1'b1;
      din = w[i];
      cycle();
    end
    din_valid = 1'b0;
    repeat (40) cycle();
    check("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_out", (out == '0), 1'b1);
`ifdef X25519_SQUEEZE_ERR_EN
    check("abort_err", err, 1'b0);
`endif
    ov_seen = 0;
    repeat (80) begin
      cycle();
      if (out_valid) ov_seen++;
    end
    check("abort_no_ov", ov_seen, 0);

    for (int i = 0; i < 32; i++) w[i] = '0;
    w[0] = 32'd256;
    run_op("t5", w, 0, -1);

    // Dropped word in round 1 leaves the result intact
    run_op("t6", w, 0, 5);
`ifdef X25519_SQUEEZE_ERR_EN
    check("t6_err", err, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_err_clr", err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/x25519_mult_squeeze.md
Name: x25519_mult_squeeze

Overview:
- Downstream neighbour of the X25519 multiply pass pipeline.
- Captures the 32 reduced product words, one per pass index i = 0..31 in order, and assembles them into a bignum.
- Runs the two-round carry "squeeze": 8-bit limbs, 2^255 ≡ 19 fold.
- Emits a squeezed bignum_t to the field ALU register file, with one valid pulse per completed multiply.

Parameters:
- None. Limb count (32) and limb width (8) come from the shared package.

Ports:
- clk  in  1  Clock; all logic on rising edge.
- rst  in  1  Synchronous, active-high reset.
- din_valid  in  1  Product word valid; wired to multiply-pass out_valid.
- din  in  32  Product word for the current index; wired to multiply-pass out.
- busy  out  1  High from first captured word until the cycle out_valid is asserted.
- out_valid  out  1  One-cycle pulse when out is updated.
- out  out  bignum_t  Squeezed result. Block k holds limb k (8 bits); upper block bits are zero.
- err  out  1  Only when X25519_SQUEEZE_ERR_EN is defined (see Optional Feature).

Behaviour:
- Reset values: busy=0, out_valid=0, out=0, err=0. Internal state: IDLE, word count 0, accumulator 0.
- rst asserted in any state returns the block to IDLE at that edge. A partial collection or squeeze is discarded; no out_valid is produced for it.
- States and transitions:
  - IDLE → COLLECT on din_valid. The word is stored to buf[0] and cnt=1.
  - COLLECT: each din_valid stores buf[cnt] and increments cnt. Gaps between words are allowed. The store of word 31 moves to SQ1 with j=0 and u=0.
  - SQ1, one limb per cycle, j=0..30: u = u + buf[j]; buf[j] = u[7:0]; u = u >> 8.
  - SQ1_TOP (1 cycle): u = u + buf[31]; buf[31] = u[6:0]; u = 19*(u >> 7).
  - SQ2: identical to SQ1, starting from the u left by SQ1_TOP.
  - SQ2_TOP: same as SQ1_TOP. At this edge, out is loaded from buf, out_valid=1, busy=0, state → IDLE.
- Accumulator u is 40 bits; it cannot overflow for 32-bit inputs. Second round: the fold value re-enters at limb 0.
- Latency: out_valid is high in the cycle following the 64th edge after the edge that captured word 31. That is 31+1+31+1 cycles.
- Throughput: 64 cycles squeeze plus ≥32 cycles collect per result.
- out holds its value until the next out_valid.
- din_valid during the out_valid cycle is legal: it is captured as word 0 of the next operation (IDLE semantics).
- din_valid while in SQ1, SQ1_TOP, SQ2 or SQ2_TOP is a protocol violation. The word is dropped; the squeeze is unaffected.
- Final result is only weakly reduced (value < 2^255 + small). Canonical reduction is the job of a separate block.

Optional Feature:
- Macro X25519_SQUEEZE_ERR_EN.
- Defined:
  - The err port exists.
  - err is a sticky flag, set on the edge after any dropped din_valid (squeeze states).
  - Cleared only by rst.
- Undefined:
  - The err port and its logic are absent.
  - Dropped words are silently ignored.

Decomposition:
- Add to Curve25519Registers:
  - Limb-width constant: 8.
  - Top-limb width constant: 7.
  - Fold constant: 19.
  - State enum type for this block.
- Sub-module x25519_squeeze_step: combinational single-limb step. Inputs: u, limb, top flag. Outputs: new limb, new u. Instanced once and shared by both rounds.

Test Plan:
1. din = 256 at index 0, all other words 0 → out.blocks[0]=0x00, out.blocks[1]=0x01, all others 0, out_valid exactly 64 cycles after word 31.
2. Words = p: 0xED, 30×0xFF, 0x7F → out equals the same limbs unchanged; busy high throughout.
3. Word 31 = 0xFFFFFFFF, others 0 → limbs 0..3 = 0xED, 0xFF, 0xFF, 0x25; limbs 4..30 = 0; limb 31 = 0x7F.
4. Word 31 = 128, others 0 → limb 0 = 19 (0x13), limb 31 = 0, all others 0.
5. rst pulsed during SQ2, then a fresh sequence of test 1 → no out_valid from the aborted run; correct result from the fresh run.
6. With X25519_SQUEEZE_ERR_EN, din_valid in SQ1 → err=1 from the next cycle and stays high; result identical to test 1 with the same data; err clears on rst.
